// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, CTRL bit layout,
// reset constants and the byte-lane write-merge helper.
package wb_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_COUNT    = 2'd2,
    REG_COMPARE  = 2'd3
  } reg_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_AUTO_RLD = 2;
  localparam int CTRL_PEND     = 8;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Merge write data into an existing 32-bit value, one byte per strobe.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] wr_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = wr_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Tick generator: one tick every (prescale+1) enabled cycles; the counter
// restarts from zero while disabled or on clear.
module timer_prescaler #(
  parameter int prescale_width = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [prescale_width-1:0] prescale,
  output logic                      tick
);

  logic [prescale_width-1:0] cnt_q, cnt_d;

  assign tick = enable & ~clear & (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic timer slave (sits on the xbar next to wb2uart, irq to core).
// Optional auto-reload on compare match is built when WB_TIMER_AUTO_RELOAD_EN is defined.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int prescale_width = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [addr_width-1:0]   wb_adr,
  input  logic [data_width-1:0]   wb_dat_i,
  input  logic [data_width/8-1:0] wb_sel,
  output logic [data_width-1:0]   wb_dat_o,
  output logic                    wb_ack,
  output logic                    irq
);

  logic                      ack_q, ack_d;
  logic [data_width-1:0]     dat_q, dat_d;
  logic                      en_q, en_d;
  logic                      irq_en_q, irq_en_d;
  logic                      pend_q, pend_d;
  logic [prescale_width-1:0] prescale_q, prescale_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               compare_q, compare_d;
  logic [data_width-1:0]     rdata;
  logic                      ar_q;

  logic unused_adr;
  assign unused_adr = ^{wb_adr[addr_width-1:4], wb_adr[1:0]};

  reg_e reg_sel;
  assign reg_sel = reg_e'(wb_adr[3:2]);

  // A request is acked one cycle after it is seen; writes land on the ack edge.
  logic acc, wr, wr_ctrl, wr_presc, wr_count, wr_cmp;
  assign acc      = wb_cyc & wb_stb;
  assign ack_d    = acc & ~ack_q;
  assign wr       = ack_q & acc & wb_we;
  assign wr_ctrl  = wr && (reg_sel == REG_CTRL);
  assign wr_presc = wr && (reg_sel == REG_PRESCALE);
  assign wr_count = wr && (reg_sel == REG_COUNT);
  assign wr_cmp   = wr && (reg_sel == REG_COMPARE);

  logic tick, match;

  timer_prescaler #(.prescale_width(prescale_width)) u_presc (
    .clock   (clock),
    .reset   (reset),
    .enable  (en_q),
    .clear   (wr_presc),
    .prescale(prescale_q),
    .tick    (tick)
  );

  assign match = tick & (count_q == compare_q);

`ifdef WB_TIMER_AUTO_RELOAD_EN
  logic ar_d;
  always_comb begin
    ar_d = ar_q;
    if (wr_ctrl && wb_sel[0]) ar_d = wb_dat_i[CTRL_AUTO_RLD];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ar_q <= 1'b0;
    else        ar_q <= ar_d;
  end
`else
  assign ar_q = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:     rdata = {23'd0, pend_q, 5'd0, ar_q, irq_en_q, en_q};
      REG_PRESCALE: rdata = 32'(prescale_q);
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    pend_d     = pend_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    dat_d      = ack_d ? rdata : '0;

    if (wr_ctrl && wb_sel[0]) begin
      en_d     = wb_dat_i[CTRL_EN];
      irq_en_d = wb_dat_i[CTRL_IRQ_EN];
    end
    if (wr_presc)
      prescale_d = prescale_width'(apply_sel(32'(prescale_q), wb_dat_i, wb_sel));
    if (wr_cmp)
      compare_d = apply_sel(compare_q, wb_dat_i, wb_sel);

    // Software write to COUNT wins over a same-cycle tick.
    if (wr_count)   count_d = apply_sel(count_q, wb_dat_i, wb_sel);
    else if (tick)  count_d = (ar_q && match) ? 32'd0 : count_q + 32'd1;

    // A match in the same cycle as a W1C keeps pending set.
    if (match)                                          pend_d = 1'b1;
    else if (wr_ctrl && wb_sel[1] && wb_dat_i[CTRL_PEND]) pend_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = pend_q & irq_en_q;

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: bus tasks queue expected read data, a
// negedge monitor pops and compares on every ack.
module tb_wb_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack, irq;

  wb_timer dut (
    .clock(clock), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] A_CTRL = 4'h0, A_PRE = 4'h4, A_CNT = 4'h8, A_CMP = 4'hC;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    string       nm;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic bus(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] exp, input string nm);
    sb_t e;
    int  n;
    e.rd = !we; e.exp = exp; e.nm = nm;
    sb.push_back(e);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = {28'd0, adr}; wb_dat_i = dat; wb_sel = sel;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wb_ack && n < 8);
    checks++;
    if (n != 1 || !wb_ack) begin
      errors++;
      $display("FAIL %s ack_latency: got %0d cycles (ack=%b) expected 1", nm, n, wb_ack);
      if (!wb_ack && sb.size() > 0) sb.delete(sb.size() - 1);
    end
    @(negedge clock);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, 4'hF, 32'd0, "write");
  endtask

  task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string nm);
    bus(1'b0, adr, 32'd0, 4'hF, exp, nm);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  // Monitor
  bit prev_ack = 1'b0;
  always @(negedge clock) begin
    sb_t e;
    if (!reset) begin
      prev_ack = 1'b0;
    end else begin
      if (wb_ack) begin
        if (prev_ack) begin
          checks++; errors++;
          $display("FAIL ack_back_to_back: got ack in two consecutive cycles expected single");
        end
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack with no access outstanding expected none");
        end else begin
          e = sb.pop_front();
          if (e.rd) chk(e.nm, wb_dat_o, e.exp);
        end
      end
      prev_ack = wb_ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    reset = 1'b1;
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_CMP, 32'hFFFF_FFFF, "rst_compare");

    // Compare match raises pending/irq seven cycles after the enabling ack
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h3);
    idle(5);
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    idle(1);
    chk("irq_on_match", {31'd0, irq}, 32'd1);
    rd(A_CNT, 32'd6, "count_at_match");
    rd(A_CTRL, 32'h103, "ctrl_pending");
    wr(A_CTRL, 32'h100);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(A_CNT, 32'd12, "count_frozen_a");
    rd(A_CNT, 32'd12, "count_frozen_b");
    rd(A_CTRL, 32'h0, "ctrl_cleared");

    // Match and W1C in the same cycle: pending survives
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    idle(2);
    wr(A_CTRL, 32'h103);
    chk("irq_same_cycle", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h0);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd(A_CTRL, 32'h100, "pending_kept");
    rd(A_CNT, 32'd6, "count_after_disable");

    // Software COUNT write beats the tick
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'd100);
    rd(A_CNT, 32'd100, "count_write_priority");
    wr(A_CTRL, 32'h100);
    rd(A_CTRL, 32'h0, "ctrl_clear2");

    // Prescaler spacing and restart on PRESCALE write
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'hFFFF_FFFF);
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h1);
    rd(A_CNT, 32'd0, "presc_0a");
    rd(A_CNT, 32'd0, "presc_0b");
    rd(A_CNT, 32'd1, "presc_1a");
    rd(A_CNT, 32'd1, "presc_1b");
    rd(A_CNT, 32'd2, "presc_2");
    idle(1);
    wr(A_PRE, 32'd3);
    idle(3);
    rd(A_CNT, 32'd3, "presc_restart");
    rd(A_CNT, 32'd4, "presc_after_restart");
    wr(A_CTRL, 32'h0);

    // Wrap at 0xFFFFFFFF
    wr(A_PRE, 32'd0);
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    rd(A_CNT, 32'd1, "count_wrap");
    rd(A_CTRL, 32'h100, "wrap_match_pending");
    wr(A_CTRL, 32'h100);

    // Byte strobes and PRESCALE width
    bus(1'b1, A_CMP, 32'hAABB_CCDD, 4'b0010, 32'd0, "sel_write");
    rd(A_CMP, 32'hFFFF_CCFF, "compare_sel");
    wr(A_PRE, 32'hFFFF_FFFF);
    rd(A_PRE, 32'h0000_FFFF, "prescale_width");
    wr(A_PRE, 32'd0);

    // Auto-reload
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h5);
    rd(A_CNT, 32'd0, "ar_seq0");
    rd(A_CNT, 32'd2, "ar_seq1");
`ifdef WB_TIMER_AUTO_RELOAD_EN
    rd(A_CNT, 32'd1, "ar_seq2");
    rd(A_CNT, 32'd0, "ar_seq3");
    rd(A_CTRL, 32'h105, "ar_ctrl");
`else
    rd(A_CNT, 32'd4, "ar_seq2");
    rd(A_CNT, 32'd6, "ar_seq3");
    rd(A_CTRL, 32'h101, "ar_ctrl");
`endif
    wr(A_CTRL, 32'h100);
    rd(A_CTRL, 32'h0, "ctrl_clear3");

    // Reset between strobe and ack
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = {28'd0, A_CMP};
    #2;
    reset = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clock);
    chk("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_mid_dat", wb_dat_o, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("no_ack_after_reset", {31'd0, wb_ack}, 32'd0);
    end
    chk("rst_irq2", {31'd0, irq}, 32'd0);
    rd(A_CTRL, 32'd0, "rst2_ctrl");
    rd(A_PRE, 32'd0, "rst2_prescale");
    rd(A_CNT, 32'd0, "rst2_count");
    rd(A_CMP, 32'hFFFF_FFFF, "rst2_compare");

    idle(2);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter addr_width, default 32, Wishbone address width.
REQ-002 SHALL have parameter data_width, default 32, Wishbone data width; only 32 supported.
REQ-003 SHALL have parameter prescale_width, default 16, prescaler counter width.
REQ-004 SHALL have ports: clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: wb_cyc, wb_stb, wb_we  input  1  Wishbone classic slave controls.
REQ-007 SHALL have ports: wb_adr  input  addr_width  byte address; only bits [3:2] decoded.
REQ-008 SHALL have ports: wb_dat_i  input  data_width  write data; wb_sel  input  data_width/8  byte strobes.
REQ-009 SHALL have ports: wb_dat_o  output  data_width  read data; wb_ack  output  1  acknowledge.
REQ-010 SHALL have ports: irq  output  1  level interrupt = pending AND irq_en.

Function
REQ-011 SHALL decode registers by adr[3:2]: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE.
REQ-012 SHALL define CTRL: bit0 enable, bit1 irq_en, bit2 auto_reload, bit8 pending (W1C); other bits read 0.
REQ-013 SHALL assert wb_ack for exactly one cycle, registered, one cycle after cyc&stb is first sampled high with ack low; ack SHALL not reassert in the cycle following an ack.
REQ-014 SHALL apply writes on the ack cycle, honoring wb_sel per byte; wb_dat_o SHALL be valid during the ack cycle and 0 otherwise.
REQ-015 SHALL generate a tick every PRESCALE+1 cycles while enable=1; PRESCALE=0 means tick every cycle; PRESCALE uses low prescale_width bits, upper bits read 0.
REQ-016 SHALL clear the prescaler counter when enable=0 or on any PRESCALE write.
REQ-017 SHALL increment COUNT by 1 on each tick, wrapping 0xFFFFFFFF -> 0.
REQ-018 SHALL set pending in the cycle after a tick on which COUNT == COMPARE (value before increment).
REQ-019 SHALL give priority: software COUNT write over tick increment in the same cycle.
REQ-020 SHALL give priority: pending set over W1C clear in the same cycle.
REQ-021 SHALL hold COUNT and pending when enable=0.

Reset
REQ-022 SHALL on reset low asynchronously clear CTRL, PRESCALE, COUNT, prescaler counter, wb_ack, wb_dat_o, irq to 0 and set COMPARE to 0xFFFFFFFF.
REQ-023 SHALL abort any in-flight access on reset; no ack SHALL be produced for it after reset release.

Configuration
REQ-024 SHALL compile auto-reload under macro WB_TIMER_AUTO_RELOAD_EN.
REQ-025 SHALL with macro defined: when auto_reload=1 and a tick matches COMPARE, load COUNT with 0 instead of incrementing.
REQ-026 SHALL without macro: CTRL bit2 not stored, reads 0; COUNT always increments.

Structure
REQ-027 SHALL place register offsets, CTRL bit positions and COMPARE reset value in shared package wb_timer_pkg.
REQ-028 SHALL implement tick generation in one sub-module timer_prescaler (inputs enable, clear, prescale; output tick).
REQ-029 SHALL connect as an xbar slave beside wb2uart, with irq routed to the core.

Verification
REQ-030 SHALL cover: PRESCALE=0, COMPARE=5, CTRL=0x3 -> pending and irq high 7 cycles after CTRL write ack, COUNT=6.
REQ-031 SHALL cover: PRESCALE=3, enable -> COUNT increments every 4 cycles; PRESCALE write mid-count restarts 4-cycle spacing.
REQ-032 SHALL cover: write CTRL=0x100 while pending -> pending 0, irq 0; same-cycle match -> pending stays 1.
REQ-033 SHALL cover: COUNT=0xFFFFFFFF, tick -> COUNT=0; wb_sel=0b0010 write 0xAABBCCDD to COMPARE -> COMPARE=0xFFFFCCFF.
REQ-034 SHALL cover: with WB_TIMER_AUTO_RELOAD_EN, COMPARE=2, CTRL=0x5 -> COUNT sequence 0,1,2,0,1,2; without macro CTRL reads 0x1.
REQ-035 SHALL cover: reset asserted between stb and ack -> no ack; all registers read reset values afterward.
